// File: rtl/online_otf_converter.sv
// online_otf_converter
//   Converts an MSB-first radix-2 signed-digit stream (online multiplier /
//   divider output) into a two's-complement integer using Q/QM on-the-fly
//   conversion, so no final carry-propagate addition is needed.
//
// Ports:
//   clk          in   rising-edge clock
//   asyn_reset   in   asynchronous, active-high reset
//   start        in   one-cycle pulse: clear state, begin a new conversion
//   digit_valid  in   digit_in carries a digit this cycle
//   digit_in     in   2'b10=+1, 2'b01=-1, 2'b00=0, 2'b11=illegal (used as 0)
//   digit_ready  out  high while digits are accepted (CONVERT)
//   result_valid out  conversion complete, result stable
//   result_ack   in   consumer has taken the result
//   result       out  N_DIGITS+1 bit two's-complement result (registered)
//   digit_err    out  sticky: illegal digit seen in the current conversion
module online_otf_converter #(
  parameter int unsigned N_DIGITS = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                clk,
  input  logic                asyn_reset,
  input  logic                start,
  input  logic                digit_valid,
  input  logic [1:0]          digit_in,
  output logic                digit_ready,
  output logic                result_valid,
  input  logic                result_ack,
  output logic [N_DIGITS:0]   result,
  output logic                digit_err
);

  localparam int unsigned W = N_DIGITS + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  // Q and QM keep only N_DIGITS bits: before the final digit |Q| < 2^(N-1),
  // so the top bit of the W-bit value is a pure sign copy. The final shift
  // produces the full W-bit result directly.
  logic [N_DIGITS-1:0] r_q;
  logic [N_DIGITS-1:0] r_qm;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [W-1:0]        r_result;

  logic         w_accept;
  logic         w_last;
  logic [W-1:0] w_q_next;
  logic [W-1:0] w_qm_next;

  assign w_accept = (r_state == S_CONVERT) && digit_valid && !start;
  assign w_last   = w_accept && (r_cnt == LAST);

  // On-the-fly append: +1 and -1 select Q or QM as the new prefix, 0 keeps each.
  always_comb begin
    w_q_next  = {r_q,  1'b0};
    w_qm_next = {r_qm, 1'b1};
    case (digit_in)
      2'b10: begin
        w_q_next  = {r_q, 1'b1};
        w_qm_next = {r_q, 1'b0};
      end
      2'b01: begin
        w_q_next  = {r_qm, 1'b1};
        w_qm_next = {r_qm, 1'b0};
      end
      default: begin
        w_q_next  = {r_q,  1'b0};
        w_qm_next = {r_qm, 1'b1};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state logic; start overrides every other event
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = S_CONVERT;
    end else begin
      case (r_state)
        S_IDLE:    w_state_next = S_IDLE;
        S_CONVERT: if (w_last) w_state_next = S_DONE;
        S_DONE:    if (result_ack) w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state only
  always_comb begin
    digit_ready  = (r_state == S_CONVERT);
    result_valid = (r_state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      r_q      <= '0;
      r_qm     <= '1;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else if (start) begin
      r_q   <= '0;
      r_qm  <= '1;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_q   <= w_q_next[N_DIGITS-1:0];
      r_qm  <= w_qm_next[N_DIGITS-1:0];
      r_cnt <= r_cnt + CNT_W'(1);
      if (digit_in == 2'b11) r_err <= 1'b1;
      if (w_last) r_result <= w_q_next;
    end
  end

  assign result    = r_result;
  assign digit_err = r_err;

endmodule

// File: doc/online_otf_converter.md
Name: online_otf_converter

Overview:
- Receives the MSB-first radix-2 signed-digit stream produced by the online multiplier/divider digit-selection stage (p_value encoding) and converts it on the fly to a conventional two's-complement result.
- Uses the Q/QM on-the-fly conversion scheme, so no carry-propagate add is needed at the end.
- Sits at the output of the online datapath and feeds the Newton-iteration control and storage in conventional binary.

Parameters:
- N_DIGITS, 16, number of signed digits per conversion; the result is N_DIGITS+1 bits wide.
- CNT_W, 5, counter width; must satisfy 2^CNT_W > N_DIGITS.

Ports:
- clk  input  1  clock, rising edge.
- asyn_reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: clear state and begin a new conversion.
- digit_valid  input  1  digit_in carries a digit this cycle.
- digit_in  input  2  signed digit: 2'b10 = +1, 2'b01 = -1, 2'b00 = 0, 2'b11 = illegal.
- digit_ready  output  1  high while the block accepts digits (state CONVERT).
- result_valid  output  1  conversion complete; result is stable.
- result_ack  input  1  consumer has taken the result.
- result  output  N_DIGITS+1  two's-complement integer equal to sum d_i*2^(N_DIGITS-i), for i = 1..N_DIGITS.
- digit_err  output  1  sticky: an illegal digit was received in the current conversion.

Behaviour:
- Reset: asyn_reset is asynchronous, active-high; clock is clk. Reset forces state IDLE, Q=0, QM=all ones (-1), count=0, result_valid=0, digit_ready=0, digit_err=0, result=0.
- FSM states: IDLE, CONVERT, DONE.
  - IDLE -> CONVERT on start.
  - CONVERT -> DONE on the cycle the N_DIGITS-th digit is accepted.
  - DONE -> IDLE on result_ack.
  - start in any state (including CONVERT and DONE) takes priority over every other event: Q=0, QM=-1, count=0, digit_err=0, state=CONVERT. A digit presented in the same cycle as start is discarded.
- Digit acceptance: a digit is accepted when state==CONVERT, digit_valid=1 and start=0. Digits offered in IDLE or DONE are ignored and change no state. Gaps in digit_valid are allowed; Q, QM and count hold during gaps.
- Update rule per accepted digit (shift left by one bit within N_DIGITS+1 bits, append one bit):
  - d=+1: Q<={Q,1}, QM<={Q,0}.
  - d=0: Q<={Q,0}, QM<={QM,1}.
  - d=-1: Q<={QM,1}, QM<={QM,0}.
  - Invariant after every update: QM == Q-1, and |Q| < 2^count, so the N_DIGITS+1-bit width never overflows.
- Illegal digit 2'b11: treated as 0 for the update, count still increments, digit_err is set and stays set until the next start or reset.
- count increments on each accepted digit. On the accept that makes count==N_DIGITS, the next state is DONE.
- Output timing:
  - result is registered and loaded from the final Q.
  - result_valid rises the cycle after the last digit is accepted (latency 1 from the last digit) and stays high until result_ack or start.
  - result holds its value after result_ack until it is overwritten by the next completion.
  - result_ack outside DONE has no effect.
- digit_ready = (state==CONVERT); it is combinational from state only.

Test Plan:
- N_DIGITS=8; start; 8 consecutive digits +1 (2'b10) -> one cycle after the 8th digit: result_valid=1, result=9'h0FF (255), digit_err=0.
- N_DIGITS=8; 8 digits -1 -> result=9'h101 (-255); then 8 digits alternating +1,-1 starting with +1 -> result=9'h055 (85).
- N_DIGITS=8; digit -1 followed by seven +1 -> result=9'h1FF (-1), which checks the QM path; all-zero digits -> result=9'h000.
- Random digit_valid gaps (0–3 idle cycles) with random digits -> result equals the signed sum computed by the reference model; count, Q and QM hold during gaps; 200 random runs.
- start asserted after 4 of 8 digits, with a digit present in the same cycle -> that digit is discarded; the next 8 digits alone determine result; digits offered while in DONE are ignored.
- Digit 2'b11 at position 3 of an otherwise all-+1 stream -> result=9'h0DF (223), digit_err=1 until the next start; asyn_reset mid-conversion -> all outputs return to 0 immediately, without waiting for a clock edge.
